// File: rtl/tinker_dmem.sv
// Byte-addressed, big-endian data memory with a fixed accept-to-response latency.
// One request is in flight at a time; the array has a single port.
`timescale 1ns/1ps
module tinker_dmem #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 524288,
  parameter int LATENCY   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(MEM_BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [7:0]        bytes [MEM_BYTES];

  logic [1:0]        state_reg;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic [3:0]        len;
  logic [ADDR_W:0]   end_addr;
  logic              err_c;
  logic              access;
  logic [IDX_W-1:0]  base;
  logic [DATA_W-1:0] load_c;

  // Range check is done one bit wider than the address so a top-of-space access cannot wrap.
  assign len      = 4'd1 << size_reg;
  assign end_addr = {1'b0, addr_reg} + (ADDR_W+1)'(len);
  assign err_c    = (int'(len) > NB)
                 || ((addr_reg[2:0] & 3'(len - 4'd1)) != 3'd0)
                 || (end_addr > (ADDR_W+1)'(MEM_BYTES));
  assign access   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign base     = addr_reg[IDX_W-1:0];

  // bytes[base] lands in the most significant byte of the right-aligned result.
  always_comb begin
    load_c = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(len) && !err_c) begin
        load_c[8*(int'(len)-1-i) +: 8] = bytes[base + IDX_W'(i)];
      end
    end
  end

  // Storage and read register carry no reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (access) begin
      if (we_reg && !err_c) begin
        for (int i = 0; i < NB; i++) begin
          if (i < int'(len)) begin
            bytes[base + IDX_W'(i)] <= wdata_reg[8*(int'(len)-1-i) +: 8];
          end
        end
      end
      rdata_reg <= (we_reg || err_c) ? '0 : load_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      size_reg  <= 2'd0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            size_reg  <= req_size;
            wdata_reg <= req_wdata;
            cnt_reg   <= 4'(LATENCY - 1);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            err_reg   <= err_c;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_valid & err_reg;
  assign rsp_rdata = rsp_valid ? rdata_reg : '0;

endmodule

// File: tb/tb_tinker_dmem.sv
// Bench for tinker_dmem: three instances (latency 3, 1, 4) sharing one clock,
// table vectors, random traffic against a byte-array model, and reset/backpressure sequences.
`timescale 1ns/1ps
module tb_tinker_dmem;

  localparam int MEM = 65536;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [1:0]  req_size  [3];
  logic [63:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [63:0] rsp_rdata [3];
  logic        rsp_err   [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      tinker_dmem #(
        .DATA_W(64), .ADDR_W(32), .MEM_BYTES(MEM),
        .LATENCY(gi == 0 ? 3 : (gi == 1 ? 1 : 4))
      ) u_dut (
        .clk(clk), .reset(reset[gi]),
        .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_we(req_we[gi]),
        .req_addr(req_addr[gi]), .req_size(req_size[gi]), .req_wdata(req_wdata[gi]),
        .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]),
        .rsp_rdata(rsp_rdata[gi]), .rsp_err(rsp_err[gi])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [MEM];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic checki(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(int i);
    return 8'(i * 37 + 11) ^ 8'(i >> 8);
  endfunction

  function automatic logic [63:0] pload(int a, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(pat(a + i));
    return v;
  endfunction

  function automatic vec_t mk(bit we, logic [31:0] a, logic [1:0] sz, logic [63:0] wd,
                              logic [63:0] rd, bit er);
    vec_t v;
    v.we = we; v.addr = a; v.size = sz; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  // Reference: big-endian byte array, alignment and no-wrap range rules in plain arithmetic.
  task automatic model_apply(bit we, logic [31:0] a, logic [1:0] sz, logic [63:0] wd,
                             output logic [63:0] rd, output logic er);
    longint la = longint'(a);
    int     n  = 1 << int'(sz);
    rd = '0;
    er = ((la % n) != 0) || (la + n > MEM);
    if (!er) begin
      for (int i = 0; i < n; i++) begin
        if (we) model_mem[la + i] = 8'(wd >> (8 * (n - 1 - i)));
        else    rd = (rd << 8) | 64'(model_mem[la + i]);
      end
    end
  endtask

  task automatic send(int k, bit we, logic [31:0] a, logic [1:0] sz, logic [63:0] wd);
    int t = 0;
    while (!req_ready[k] && t < 100) begin
      @(posedge clk); #1; t++;
    end
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_size[k] = sz; req_wdata[k] = wd;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    check1($sformatf("accept_k%0d_a%h", k, a), req_ready[k], 1'b0);
  endtask

  task automatic wait_rsp(int k, output int lat);
    lat = 0;
    while (!rsp_valid[k] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume(int k);
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  task automatic txn(int k, bit we, logic [31:0] a, logic [1:0] sz, logic [63:0] wd,
                     output logic [63:0] rd, output logic er, output int lat);
    send(k, we, a, sz, wd);
    wait_rsp(k, lat);
    rd = rsp_rdata[k];
    er = rsp_err[k];
    consume(k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, mrd;
    logic        er, mer;
    int          lat;
    int          acc_cyc [4];
    int          rsp_cyc [4];
    int          nacc, nrsp, cyc;
    bit          seen;

    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_size[k] = 2'd0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    for (int i = 0; i < MEM; i++) begin
      g_dut[0].u_dut.bytes[i] <= pat(i);
      g_dut[1].u_dut.bytes[i] <= pat(i);
      g_dut[2].u_dut.bytes[i] <= pat(i);
      model_mem[i] = pat(i);
    end

    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check1($sformatf("rst_ready_k%0d", k), req_ready[k], 1'b1);
      check1($sformatf("rst_valid_k%0d", k), rsp_valid[k], 1'b0);
      check1($sformatf("rst_err_k%0d", k), rsp_err[k], 1'b0);
      check64($sformatf("rst_rdata_k%0d", k), rsp_rdata[k], 64'd0);
    end
    #2;
    for (int k = 0; k < 3; k++) reset[k] = 1'b1;

    // Directed vectors on the latency-3 instance; the first accept is the first edge after release.
    vecs.push_back(mk(1, 32'h2000, 2'd3, 64'h0123456789ABCDEF, 64'h0, 0));
    vecs.push_back(mk(0, 32'h2000, 2'd3, 64'h0, 64'h0123456789ABCDEF, 0));
    vecs.push_back(mk(0, 32'h2000, 2'd0, 64'h0, 64'h01, 0));
    vecs.push_back(mk(0, 32'h2007, 2'd0, 64'h0, 64'hEF, 0));
    vecs.push_back(mk(1, 32'h2003, 2'd0, 64'hDEADBEEFCAFE12FF, 64'h0, 0));
    vecs.push_back(mk(0, 32'h2002, 2'd1, 64'h0, 64'h45FF, 0));
    vecs.push_back(mk(0, 32'h2000, 2'd3, 64'h0, 64'h012345FF89ABCDEF, 0));
    vecs.push_back(mk(0, 32'h2004, 2'd2, 64'h0, 64'h89ABCDEF, 0));
    vecs.push_back(mk(0, 32'h2001, 2'd1, 64'h0, 64'h0, 1));
    vecs.push_back(mk(1, 32'(MEM - 4), 2'd3, 64'h1111111111111111, 64'h0, 1));
    vecs.push_back(mk(0, 32'(MEM - 4), 2'd2, 64'h0, pload(MEM - 4, 4), 0));
    vecs.push_back(mk(0, 32'hFFFFFFF8, 2'd3, 64'h0, 64'h0, 1));
    vecs.push_back(mk(1, 32'hFFFFFFF8, 2'd3, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1));
    vecs.push_back(mk(0, 32'(MEM - 8), 2'd3, 64'h0, pload(MEM - 8, 8), 0));
    for (int i = 0; i < vecs.size(); i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, er, lat);
      model_apply(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, mrd, mer);
      check64($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check1($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      checki($sformatf("vec%0d_lat", i), lat, 3);
      $display("vec %0d we=%0d addr=%h size=%0d rdata=%h err=%0d lat=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].size, rd, er, lat);
    end
    check64("store_msb_byte", 64'(g_dut[0].u_dut.bytes['h2000]), 64'h01);
    check64("store_lsb_byte", 64'(g_dut[0].u_dut.bytes['h2007]), 64'hEF);

    // Backpressure: response held 5 cycles while a stray request pulse is offered.
    send(0, 1'b0, 32'h2000, 2'd3, 64'h0);
    wait_rsp(0, lat);
    checki("bp_lat", lat, 3);
    for (int c = 0; c < 5; c++) begin
      check1($sformatf("bp_valid_c%0d", c), rsp_valid[0], 1'b1);
      check64($sformatf("bp_rdata_c%0d", c), rsp_rdata[0], 64'h012345FF89ABCDEF);
      check1($sformatf("bp_ready_c%0d", c), req_ready[0], 1'b0);
      if (c == 1) begin
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h2000;
        req_size[0] = 2'd3; req_wdata[0] = 64'h0;
      end else begin
        req_valid[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    consume(0);
    check1("bp_idle_after", req_ready[0], 1'b1);
    txn(0, 1'b0, 32'h2000, 2'd3, 64'h0, rd, er, lat);
    check64("bp_pulse_ignored", rd, 64'h012345FF89ABCDEF);
    $display("backpressure done rdata=%h", rd);

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      int          r;
      bit          we;
      logic [31:0] a;
      logic [1:0]  sz;
      logic [63:0] wd;
      r  = int'($urandom_range(0, 99));
      if (r < 70)      a = 32'h1F00 + 32'($urandom_range(0, 511));
      else if (r < 85) a = 32'(MEM) - 32'($urandom_range(1, 16));
      else             a = $urandom;
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      txn(0, we, a, sz, wd, rd, er, lat);
      model_apply(we, a, sz, wd, mrd, mer);
      check64($sformatf("rnd%0d_rdata", i), rd, mrd);
      check1($sformatf("rnd%0d_err", i), er, mer);
      checki($sformatf("rnd%0d_lat", i), lat, 3);
      $display("rnd %0d we=%0d addr=%h size=%0d rdata=%h err=%0d", i, we, a, sz, rd, er);
    end

    // Reset during BUSY on the latency-4 instance: the store must never commit.
    send(2, 1'b1, 32'h100, 2'd0, 64'hAA);
    @(posedge clk); @(posedge clk); #2;
    reset[2] = 1'b0;
    #1;
    check1("rstbusy_ready", req_ready[2], 1'b1);
    check1("rstbusy_valid", rsp_valid[2], 1'b0);
    check1("rstbusy_err", rsp_err[2], 1'b0);
    check64("rstbusy_rdata", rsp_rdata[2], 64'h0);
    @(posedge clk); @(posedge clk); #3;
    reset[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[2]) seen = 1'b1;
    end
    check1("rstbusy_no_rsp", seen, 1'b0);
    check64("rstbusy_byte", 64'(g_dut[2].u_dut.bytes['h100]), 64'(pat('h100)));
    txn(2, 1'b0, 32'h100, 2'd0, 64'h0, rd, er, lat);
    check64("rstbusy_load", rd, 64'(pat('h100)));
    checki("rstbusy_lat", lat, 4);
    $display("reset-in-busy load rdata=%h lat=%0d", rd, lat);

    // Reset during RESP: response dropped, committed store retained.
    send(2, 1'b1, 32'h104, 2'd0, 64'h77);
    wait_rsp(2, lat);
    check1("rstresp_valid_before", rsp_valid[2], 1'b1);
    #2;
    reset[2] = 1'b0;
    #1;
    check1("rstresp_valid_after", rsp_valid[2], 1'b0);
    @(posedge clk); #3;
    reset[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[2]) seen = 1'b1;
    end
    check1("rstresp_no_rsp", seen, 1'b0);
    txn(2, 1'b0, 32'h104, 2'd0, 64'h0, rd, er, lat);
    check64("rstresp_load", rd, 64'h77);
    $display("reset-in-resp load rdata=%h", rd);

    // Latency-1 throughput with rsp_ready held high.
    rsp_ready[1] = 1'b1;
    nacc = 0; nrsp = 0; cyc = 0;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd3; req_addr[1] = 32'h40;
    while (nrsp < 4 && cyc < 60) begin
      bit acc_now;
      acc_now = req_valid[1] && req_ready[1];
      @(posedge clk); #1; cyc++;
      if (acc_now) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 4) req_valid[1] = 1'b0;
        else           req_addr[1] = 32'h40 + 32'(8 * nacc);
      end
      if (rsp_valid[1] && nrsp < 4) begin
        rsp_cyc[nrsp] = cyc;
        check64($sformatf("tp%0d_rdata", nrsp), rsp_rdata[1], pload('h40 + 8 * nrsp, 8));
        $display("tp %0d rdata=%h cycle=%0d", nrsp, rsp_rdata[1], cyc);
        nrsp++;
      end
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    checki("tp_responses", nrsp, 4);
    if (nrsp == 4) begin
      for (int i = 0; i < 4; i++) begin
        checki($sformatf("tp%0d_lat", i), rsp_cyc[i] - acc_cyc[i], 1);
        if (i > 0) checki($sformatf("tp%0d_spacing", i), acc_cyc[i] - acc_cyc[i-1], 3);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
